// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LCD path: scans h/v counters, presents the active
// pixel coordinate to the renderer and registers its colour with aligned sync/DE strobes.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 13,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 29
) (
  input  logic        iclk,
  input  logic        iRST,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  output logic [10:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  output logic [7:0]  oLCD_R,
  output logic [7:0]  oLCD_G,
  output logic [7:0]  oLCD_B,
  output logic        oDE,
  output logic        oHSYNC_N,
  output logic        oVSYNC_N,
  output logic        oFrame_tick
);

  localparam int unsigned CW           = 11;
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;
  logic          w_hsync;
  logic          w_vsync;

  assign w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));

  // Raster counters; v advances only on the h wrap, both wrap together at frame end.
  always_ff @(posedge iclk) begin
    if (iRST) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CW'(1);
    end
  end

  assign w_active = (r_h_cnt < CW'(H_ACTIVE)) && (r_v_cnt < CW'(V_ACTIVE));
  assign w_hsync  = (r_h_cnt >= CW'(H_SYNC_START)) && (r_h_cnt < CW'(H_SYNC_END));
  assign w_vsync  = (r_v_cnt >= CW'(V_SYNC_START)) && (r_v_cnt < CW'(V_SYNC_END));

  assign oCoord_X    = w_active ? r_h_cnt : '0;
  assign oCoord_Y    = w_active ? r_v_cnt : '0;
  assign oFrame_tick = !iRST && (r_h_cnt == '0) && (r_v_cnt == CW'(V_ACTIVE));

  // Panel stage: one clock behind the coordinate so renderer colour lines up with strobes.
  always_ff @(posedge iclk) begin
    if (iRST) begin
      oDE      <= 1'b0;
      oHSYNC_N <= 1'b1;
      oVSYNC_N <= 1'b1;
      oLCD_R   <= '0;
      oLCD_G   <= '0;
      oLCD_B   <= '0;
    end else begin
      oDE      <= w_active;
      oHSYNC_N <= !w_hsync;
      oVSYNC_N <= !w_vsync;
      oLCD_R   <= w_active ? iRed   : '0;
      oLCD_G   <= w_active ? iGreen : '0;
      oLCD_B   <= w_active ? iBlue  : '0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a full-size instance for line timing and a reduced-raster
// instance for frame timing, both checked every cycle against a reference raster model.
module tb_lcd_timing_gen;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [10:0] h;
    logic [10:0] v;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
  } pair_t;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        iRST;
  int          mode;
  logic [7:0]  rnd_r, rnd_g, rnd_b;

  logic [7:0]  red0, grn0, blu0, lr0, lg0, lb0;
  logic [10:0] cx0, cy0;
  logic        de0, hs0, vs0, tk0;
  logic [7:0]  red1, grn1, blu1, lr1, lg1, lb1;
  logic [10:0] cx1, cy1;
  logic        de1, hs1, vs1, tk1;

  lcd_timing_gen u_dut (
    .iclk(iclk), .iRST(iRST), .iRed(red0), .iGreen(grn0), .iBlue(blu0),
    .oCoord_X(cx0), .oCoord_Y(cy0), .oLCD_R(lr0), .oLCD_G(lg0), .oLCD_B(lb0),
    .oDE(de0), .oHSYNC_N(hs0), .oVSYNC_N(vs0), .oFrame_tick(tk0)
  );

  lcd_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)
  ) u_small (
    .iclk(iclk), .iRST(iRST), .iRed(red1), .iGreen(grn1), .iBlue(blu1),
    .oCoord_X(cx1), .oCoord_Y(cy1), .oLCD_R(lr1), .oLCD_G(lg1), .oLCD_B(lb1),
    .oDE(de1), .oHSYNC_N(hs1), .oVSYNC_N(vs1), .oFrame_tick(tk1)
  );

  // Renderer stand-in: random, constant white, or colour derived from the coordinate.
  always_comb begin
    case (mode)
      1:       begin red0 = 8'hFF;     grn0 = 8'hFF;     blu0 = 8'hFF; end
      2:       begin red0 = cx0[7:0];  grn0 = cy0[7:0];  blu0 = cx0[7:0] ^ cy0[7:0]; end
      default: begin red0 = rnd_r;     grn0 = rnd_g;     blu0 = rnd_b; end
    endcase
  end

  always_comb begin
    case (mode)
      1:       begin red1 = 8'hFF;     grn1 = 8'hFF;     blu1 = 8'hFF; end
      2:       begin red1 = cx1[7:0];  grn1 = cy1[7:0];  blu1 = cx1[7:0] ^ cy1[7:0]; end
      default: begin red1 = rnd_r;     grn1 = rnd_g;     blu1 = rnd_b; end
    endcase
  end

  int ha[2], hfp[2], hsw[2], hbp[2], va[2], vfp[2], vsw[2], vbp[2];
  int mh[2], mv[2];
  pair_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Aggregate trackers
  bit line_win = 1'b0;
  int de_cnt_l0 = 0, hs_lo_l0 = 0, hs_first_l0 = -1;
  int de_rise[$];
  bit prev_de0 = 1'b0;
  bit last_rst = 1'b1;
  int rel_cyc  = 0;
  bit have_prev = 1'b0;
  int prev_tick = 0;
  int vs_lo_since = 0, de_since = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model_exp(input int i, input logic rst);
    exp_t e;
    logic act;
    int   hs0_, vs0_;
    act  = (mh[i] < ha[i]) && (mv[i] < va[i]);
    hs0_ = ha[i] + hfp[i];
    vs0_ = va[i] + vfp[i];
    e.h  = 11'(mh[i]);
    e.v  = 11'(mv[i]);
    if (rst) begin
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.r = '0; e.g = '0; e.b = '0;
    end else begin
      e.de = act;
      e.hs = !((mh[i] >= hs0_) && (mh[i] < hs0_ + hsw[i]));
      e.vs = !((mv[i] >= vs0_) && (mv[i] < vs0_ + vsw[i]));
      if (!act) begin
        e.r = '0; e.g = '0; e.b = '0;
      end else if (mode == 1) begin
        e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF;
      end else if (mode == 2) begin
        e.r = 8'(mh[i]); e.g = 8'(mv[i]); e.b = 8'(mh[i]) ^ 8'(mv[i]);
      end else begin
        e.r = rnd_r; e.g = rnd_g; e.b = rnd_b;
      end
    end
    return e;
  endfunction

  task automatic cmp_regs(input string p, input exp_t e, input logic de, input logic hs,
                          input logic vs, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    chk($sformatf("%s_de(%0d,%0d)", p, e.h, e.v), 32'(de), 32'(e.de));
    chk($sformatf("%s_hsync_n(%0d,%0d)", p, e.h, e.v), 32'(hs), 32'(e.hs));
    chk($sformatf("%s_vsync_n(%0d,%0d)", p, e.h, e.v), 32'(vs), 32'(e.vs));
    chk($sformatf("%s_rgb(%0d,%0d)", p, e.h, e.v), {8'h0, r, g, b}, {8'h0, e.r, e.g, e.b});
  endtask

  // One pixel clock: drive, check coordinate/tick, push expectation, pop after the edge.
  task automatic step(input logic rst);
    exp_t  e[2];
    pair_t q;
    logic  act;
    iRST  = rst;
    rnd_r = 8'($urandom);
    rnd_g = 8'($urandom);
    rnd_b = 8'($urandom);
    #1;
    cyc++;
    if (!rst && last_rst) rel_cyc = cyc;
    if (rst) have_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      act = (mh[i] < ha[i]) && (mv[i] < va[i]);
      chk($sformatf("coord_x%0d", i), 32'(i == 0 ? cx0 : cx1), act ? 32'(mh[i]) : 32'd0);
      chk($sformatf("coord_y%0d", i), 32'(i == 0 ? cy0 : cy1), act ? 32'(mv[i]) : 32'd0);
      chk($sformatf("tick%0d(%0d,%0d)", i, mh[i], mv[i]), 32'(i == 0 ? tk0 : tk1),
          32'(!rst && mh[i] == 0 && mv[i] == va[i]));
      e[i] = model_exp(i, rst);
    end
    if (tk1 === 1'b1) begin
      if (have_prev) begin
        chk("frame_period", 32'(cyc - prev_tick), 32'd544);
        chk("vsync_lo_per_frame", 32'(vs_lo_since), 32'd96);
        chk("de_per_frame", 32'(de_since), 32'd200);
      end else begin
        chk("first_tick_latency", 32'(cyc - rel_cyc), 32'd320);
      end
      have_prev   = 1'b1;
      prev_tick   = cyc;
      vs_lo_since = 0;
      de_since    = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mh[i] = 0; mv[i] = 0;
      end else if (mh[i] == ha[i] + hfp[i] + hsw[i] + hbp[i] - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == va[i] + vfp[i] + vsw[i] + vbp[i] - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
    end
    last_rst = rst;
    sb.push_back('{e0: e[0], e1: e[1]});
    @(posedge iclk);
    #1;
    q = sb.pop_front();
    cmp_regs("big", q.e0, de0, hs0, vs0, lr0, lg0, lb0);
    cmp_regs("small", q.e1, de1, hs1, vs1, lr1, lg1, lb1);
    if (mode == 2 && q.e1.h == 11'd19 && q.e1.v == 11'd9) begin
      chk("corner_r", 32'(lr1), 32'h13);
      chk("corner_g", 32'(lg1), 32'h09);
    end
    if (mode == 2 && q.e0.h == 11'd799 && q.e0.de) chk("x799_r", 32'(lr0), 32'h1F);
    if (line_win && q.e0.v == 11'd0) begin
      if (de0 === 1'b1) de_cnt_l0++;
      if (hs0 === 1'b0) begin
        hs_lo_l0++;
        if (hs_first_l0 < 0) hs_first_l0 = int'(q.e0.h);
      end
    end
    if (line_win && de0 === 1'b1 && !prev_de0) de_rise.push_back(cyc);
    prev_de0 = (de0 === 1'b1);
    if (vs1 === 1'b0) vs_lo_since++;
    if (de1 === 1'b1) de_since++;
  endtask

  initial begin
    ha  = '{800, 20}; hfp = '{40, 3}; hsw = '{48, 4}; hbp = '{88, 5};
    va  = '{480, 10}; vfp = '{13, 2}; vsw = '{3, 3};  vbp = '{29, 2};
    mh  = '{0, 0};    mv  = '{0, 0};
    mode = 0; rnd_r = '0; rnd_g = '0; rnd_b = '0;
    iRST = 1'b1;
    repeat (2) @(posedge iclk);
    #1;

    // Reset held with random colour in
    for (int k = 0; k < 5; k++) step(1'b1);

    // Release and run two full-size lines
    line_win = 1'b1;
    for (int k = 0; k < 1952; k++) step(1'b0);
    line_win = 1'b0;
    chk("line_de_count", 32'(de_cnt_l0), 32'd800);
    chk("line_hsync_lo_count", 32'(hs_lo_l0), 32'd48);
    chk("line_hsync_first_h", 32'(hs_first_l0), 32'd840);
    chk("line_de_rises", 32'(de_rise.size()), 32'd2);
    if (de_rise.size() >= 2) chk("line_length", 32'(de_rise[1] - de_rise[0]), 32'd976);

    // Constant white input: colour must be black outside active area
    mode = 1;
    for (int k = 0; k < 600; k++) step(1'b0);

    // Coordinate-derived colour for alignment
    mode = 2;
    for (int k = 0; k < 600; k++) step(1'b0);

    // Reset landing exactly on the tick position of the small raster
    mode = 0;
    for (int k = 0; k < 600 && !(mh[1] == 0 && mv[1] == 10); k++) step(1'b0);
    step(1'b1);
    for (int k = 0; k < 100; k++) step(1'b0);

    // Mid-frame reset, then a full frame and more
    for (int k = 0; k < 600 && !(mh[1] == 10 && mv[1] == 5); k++) step(1'b0);
    step(1'b1);
    for (int k = 0; k < 1200; k++) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
